apb_rr_arbiter_master: RTL

- APB master front-end that shares one APB bus between NREQ requester ports using round-robin arbitration.
- Accepts one command per grant (read/write, address, write data) and sequences the APB SETUP/ACCESS phases.
- Returns read data, or a timeout error, to the granted requester.
- Sits between the system requesters and the APB slaves, in place of the single-requester master driven by i_TRANSACTION/i_RW.

---
 rtl/apb_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/apb_rr_arbiter_master.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the round-robin APB master front-end:
//   - FSM state encoding (IDLE/SETUP/ACCESS/RESP)
//   - transfer direction encoding (RW_READ/RW_WRITE)
//   - default address/data widths
//   - wrap_add(): modular add used to walk the requester ring
// No ports (package).
// -----------------------------------------------------------------------------
package apb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int DEF_WADDR = 8;
  localparam int DEF_WDATA = 8;

  // (base + off) mod n, for walking a ring of n slots starting at base.
  function automatic int wrap_add(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts at i_ptr and
// walks upward, wrapping modulo NREQ; the first asserted request wins.
// Ports:
//   i_req        request vector
//   i_ptr        index that has highest priority this cycle
//   o_grant      one-hot grant (all zero when no request)
//   o_grant_idx  binary index of the granted request (0 when none)
//   o_any        at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter
  import apb_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_grant_idx,
  output logic            o_any
);

  logic [PW-1:0] w_idx;

  // Priority scan from the pointer; later hits are ignored once one is found.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_idx       = '0;
    for (int d = 0; d < NREQ; d++) begin
      w_idx = PW'(wrap_add(int'(i_ptr), d, NREQ));
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end else begin
        // an earlier slot in the ring already holds the grant
      end
    end
  end

endmodule

// File: rtl/apb_rr_arbiter_master.sv
// -----------------------------------------------------------------------------
// apb_rr_arbiter_master
// APB master shared between NREQ requesters. In IDLE a round-robin arbiter
// picks one valid requester and accepts its command; the FSM then runs one
// APB SETUP cycle, ACCESS cycles until PREADY (or TIMEOUT ACCESS cycles), and
// a one-cycle RESP that pulses the requester's response bit.
// Ports:
//   i_PCLK, i_PRESETn            clock, synchronous active-low reset
//   i_REQ_VALID/RW/ADDR/WDATA    per-requester command (packed k*W +: W)
//   o_REQ_READY                  one-hot accept, combinational, IDLE only
//   o_RSP_VALID/ERR/RDATA        one-hot completion pulse, timeout flag, data
//   o_PSEL/PENABLE/PWRITE/PADDR/PWDATA, i_PREADY/i_PRDATA   APB bus
// -----------------------------------------------------------------------------
module apb_rr_arbiter_master
  import apb_pkg::*;
#(
  parameter  int NREQ    = 2,
  parameter  int WADDR   = DEF_WADDR,
  parameter  int WDATA   = DEF_WDATA,
  parameter  int TIMEOUT = 16
) (
  input  logic                   i_PCLK,
  input  logic                   i_PRESETn,
  input  logic [NREQ-1:0]        i_REQ_VALID,
  output logic [NREQ-1:0]        o_REQ_READY,
  input  logic [NREQ-1:0]        i_REQ_RW,
  input  logic [NREQ*WADDR-1:0]  i_REQ_ADDR,
  input  logic [NREQ*WDATA-1:0]  i_REQ_WDATA,
  output logic [NREQ-1:0]        o_RSP_VALID,
  output logic                   o_RSP_ERR,
  output logic [WDATA-1:0]       o_RSP_RDATA,
  output logic                   o_PSEL,
  output logic                   o_PENABLE,
  output logic                   o_PWRITE,
  output logic [WADDR-1:0]       o_PADDR,
  output logic [WDATA-1:0]       o_PWDATA,
  input  logic                   i_PREADY,
  input  logic [WDATA-1:0]       i_PRDATA
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

  logic [1:0]       r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_gidx;
  logic [CW-1:0]    r_cnt;
  logic             r_psel;
  logic             r_penable;
  logic             r_pwrite;
  logic [WADDR-1:0] r_paddr;
  logic [WDATA-1:0] r_pwdata;
  logic [NREQ-1:0]  r_rsp_valid;
  logic             r_rsp_err;
  logic [WDATA-1:0] r_rsp_rdata;

  logic [NREQ-1:0]  w_grant;
  logic [PW-1:0]    w_gidx;
  logic             w_any;
  logic             w_rw_sel;
  logic [WADDR-1:0] w_addr_sel;
  logic [WDATA-1:0] w_wdata_sel;
  logic [NREQ-1:0]  w_rsp_vec;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req       (i_REQ_VALID),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx),
    .o_any       (w_any)
  );

  // Pick out the granted requester's command slices.
  always_comb begin
    w_rw_sel    = 1'b0;
    w_addr_sel  = '0;
    w_wdata_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gidx == PW'(k)) begin
        w_rw_sel    = i_REQ_RW[k];
        w_addr_sel  = i_REQ_ADDR[k*WADDR +: WADDR];
        w_wdata_sel = i_REQ_WDATA[k*WDATA +: WDATA];
      end else begin
        // not the granted slot
      end
    end
  end

  // Accept strobe: only in IDLE and never while reset is held.
  always_comb begin
    if (i_PRESETn && (r_state == ST_IDLE)) begin
      o_REQ_READY = w_grant;
    end else begin
      o_REQ_READY = '0;
    end
  end

  assign w_rsp_vec = {{(NREQ-1){1'b0}}, 1'b1} << r_gidx;

  // Transfer FSM; APB and response outputs are registered alongside the state
  // so they line up with it (PSEL rises on the accept edge, etc.).
  always_ff @(posedge i_PCLK) begin
    if (!i_PRESETn) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gidx      <= '0;
      r_cnt       <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gidx   <= w_gidx;
            r_pwrite <= w_rw_sel;
            r_paddr  <= w_addr_sel;
            r_pwdata <= w_wdata_sel;
            r_psel   <= 1'b1;
            r_state  <= ST_SETUP;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          // PREADY is deliberately not looked at here
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // Success is tested first so PREADY on the last allowed cycle wins.
          if (i_PREADY) begin
            r_rsp_rdata <= (r_pwrite == RW_READ) ? i_PRDATA : '0;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= w_rsp_vec;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= ST_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= w_rsp_vec;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_rsp_valid <= '0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
          r_cnt       <= '0;
          r_ptr       <= (r_gidx == PTR_LAST) ? '0 : (r_gidx + 1'b1);
          r_state     <= ST_IDLE;
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_cnt     <= '0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_RSP_VALID = r_rsp_valid;
  assign o_RSP_ERR   = r_rsp_err;
  assign o_RSP_RDATA = r_rsp_rdata;
  assign o_PSEL      = r_psel;
  assign o_PENABLE   = r_penable;
  assign o_PWRITE    = r_pwrite;
  assign o_PADDR     = r_paddr;
  assign o_PWDATA    = r_pwdata;

endmodule
